mem_host_master: RTL and testbench



---
 rtl/mem_host_master_pkg.sv | 43 ++++
 rtl/mem_host_master_if.sv | 43 ++++
 rtl/mem_host_master.sv | 170 +++++++++++++++++
 tb/tb_mem_host_master.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_host_master_pkg.sv
// Shared definitions for the host-side memory port initiator: port op
// encodings, the halted-register address, FSM state type and small helpers.
package mem_host_master_pkg;

    localparam logic [1:0]  MEM_OP_NOP      = 2'h0;
    localparam logic [1:0]  MEM_OP_READ     = 2'h1;
    localparam logic [1:0]  MEM_OP_WRITE    = 2'h2;
    localparam logic [1:0]  REQ_OP_POLL     = 2'h3;

    localparam logic [63:0] MEM_ADDR_HALTED = 64'h8000_0000_0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Saturating increment for the 16-bit attempt/wait/gap counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    // Request op to port op: a POLL is carried out as a READ, the port never sees op 3.
    function automatic logic [1:0] port_op(input logic [1:0] req_op);
        logic [1:0] result;
        case (req_op)
            MEM_OP_READ:  result = MEM_OP_READ;
            MEM_OP_WRITE: result = MEM_OP_WRITE;
            REQ_OP_POLL:  result = MEM_OP_READ;
            default:      result = MEM_OP_NOP;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_host_master_if.sv
// Request, response and memory-port signals between the host transport,
// the initiator and the core's memory/register access port.
interface mem_host_master_if;

    // request channel (host -> initiator)
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_addr;
    logic [63:0] req_data;

    // response channel (initiator -> host)
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_timeout;

    // memory/register port (initiator <-> core)
    logic [1:0]  mem_op;
    logic [63:0] mem_addr;
    logic [63:0] mem_data;
    logic [63:0] mem_rdata;
    logic        mem_op_pending;

    modport master (
        input  req_valid, req_op, req_addr, req_data,
        input  rsp_ready,
        input  mem_rdata, mem_op_pending,
        output req_ready,
        output rsp_valid, rsp_data, rsp_timeout,
        output mem_op, mem_addr, mem_data
    );

    modport slave (
        output req_valid, req_op, req_addr, req_data,
        output rsp_ready,
        output mem_rdata, mem_op_pending,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_timeout,
        input  mem_op, mem_addr, mem_data
    );

endinterface

// File: rtl/mem_host_master.sv
// Host-side initiator: takes one READ/WRITE/POLL/NOP request at a time,
// drives a one-cycle op on the memory port, waits out the pending-read
// window, and returns exactly one response per request. All outputs are
// registered; reset is asynchronous and forces the port op back to NOP.
module mem_host_master
    import mem_host_master_pkg::*;
#(
    parameter int POLL_LIMIT = 1024,
    parameter int PEND_LIMIT = 16,
    parameter int POLL_GAP   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mem_host_master_if.master bus
);

    // Limits widened by one bit so "count + 1 >= limit" cannot wrap.
    localparam logic [16:0] POLL_LIMIT_C = 17'(POLL_LIMIT);
    localparam logic [16:0] PEND_LIMIT_C = 17'(PEND_LIMIT);
    localparam logic [16:0] POLL_GAP_C   = 17'(POLL_GAP);

    state_t      state_r;
    logic [1:0]  op_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [63:0] rsp_data_r;
    logic        rsp_timeout_r;
    logic [1:0]  mem_op_r;
    logic [63:0] mem_addr_r;
    logic [63:0] mem_data_r;
    logic [15:0] pend_cnt_r;
    logic [15:0] poll_cnt_r;
    logic [15:0] gap_cnt_r;

    logic        pend_hit_s;
    logic        poll_hit_s;
    logic        gap_done_s;
    logic [63:0] cap_data_s;
    logic        poll_retry_s;

    // Limit detection: true on the cycle whose count would reach the limit.
    always_comb begin
        pend_hit_s = (({1'b0, pend_cnt_r} + 17'd1) >= PEND_LIMIT_C);
        poll_hit_s = (({1'b0, poll_cnt_r} + 17'd1) >= POLL_LIMIT_C);
        gap_done_s = (({1'b0, gap_cnt_r}  + 17'd1) >= POLL_GAP_C);
    end

    // Data captured when pending is low in WAIT: writes report 0, reads/polls the port data.
    always_comb begin
        cap_data_s   = 64'h0;
        poll_retry_s = 1'b0;
        if (op_r == MEM_OP_WRITE) begin
            cap_data_s = 64'h0;
        end else begin
            cap_data_s = bus.mem_rdata;
        end
        if ((op_r == REQ_OP_POLL) && (cap_data_s[0] == 1'b0)) begin
            poll_retry_s = 1'b1;
        end else begin
            poll_retry_s = 1'b0;
        end
    end

    // Request/response FSM with all port and handshake outputs registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r       <= ST_IDLE;
            op_r          <= MEM_OP_NOP;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= 64'h0;
            rsp_timeout_r <= 1'b0;
            mem_op_r      <= MEM_OP_NOP;
            mem_addr_r    <= 64'h0;
            mem_data_r    <= 64'h0;
            pend_cnt_r    <= 16'h0;
            poll_cnt_r    <= 16'h0;
            gap_cnt_r     <= 16'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_r) begin
                        op_r          <= bus.req_op;
                        req_ready_r   <= 1'b0;
                        rsp_data_r    <= 64'h0;
                        rsp_timeout_r <= 1'b0;
                        pend_cnt_r    <= 16'h0;
                        poll_cnt_r    <= 16'h0;
                        gap_cnt_r     <= 16'h0;
                        if (bus.req_op == MEM_OP_NOP) begin
                            rsp_valid_r <= 1'b1;
                            state_r     <= ST_RESP;
                        end else begin
                            // port op is registered here so it is visible during ISSUE only
                            mem_op_r   <= port_op(bus.req_op);
                            mem_addr_r <= bus.req_addr;
                            mem_data_r <= bus.req_data;
                            state_r    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // pending is not valid yet; it appears one edge after the op
                    mem_op_r   <= MEM_OP_NOP;
                    pend_cnt_r <= 16'h0;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mem_op_pending) begin
                        if (pend_hit_s) begin
                            rsp_timeout_r <= 1'b1;
                            rsp_valid_r   <= 1'b1;
                            state_r       <= ST_RESP;
                        end else begin
                            pend_cnt_r <= sat_inc16(pend_cnt_r);
                        end
                    end else begin
                        rsp_data_r <= cap_data_s;
                        if (poll_retry_s) begin
                            poll_cnt_r <= sat_inc16(poll_cnt_r);
                            if (poll_hit_s) begin
                                rsp_timeout_r <= 1'b1;
                                rsp_valid_r   <= 1'b1;
                                state_r       <= ST_RESP;
                            end else begin
                                gap_cnt_r <= 16'h0;
                                state_r   <= ST_GAP;
                            end
                        end else begin
                            rsp_valid_r <= 1'b1;
                            state_r     <= ST_RESP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_done_s) begin
                        // re-issue the poll read at the same address
                        mem_op_r <= MEM_OP_READ;
                        state_r  <= ST_ISSUE;
                    end else begin
                        gap_cnt_r <= sat_inc16(gap_cnt_r);
                    end
                end
                ST_RESP: begin
                    // response held stable for as long as the consumer stalls
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    mem_op_r    <= MEM_OP_NOP;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_data    = rsp_data_r;
    assign bus.rsp_timeout = rsp_timeout_r;
    assign bus.mem_op      = mem_op_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_data    = mem_data_r;

endmodule

// File: tb/tb_mem_host_master.sv
// Self-checking bench for mem_host_master: a behavioural port model answers
// the memory port, expected responses go into a scoreboard queue when a
// request is driven and are popped when the DUT raises o_rsp_valid.
// Latency is counted in clock edges starting with the handshake edge.
module tb_mem_host_master;
    import mem_host_master_pkg::*;

    localparam int POLL_LIMIT = 8;
    localparam int PEND_LIMIT = 16;
    localparam int POLL_GAP   = 4;

    logic clk = 1'b0;
    logic rst;

    mem_host_master_if bus ();

    mem_host_master #(
        .POLL_LIMIT (POLL_LIMIT),
        .PEND_LIMIT (PEND_LIMIT),
        .POLL_GAP   (POLL_GAP)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // port model state
    logic [63:0] mem_arr [16];
    int          halted_reads      = 0;
    int          halted_zero_until = 0;
    logic        pend_stuck;

    // port op monitor counters (cumulative; tests take differences)
    int          n_read   = 0;
    int          n_write  = 0;
    int          n_long   = 0;
    int          n_bad    = 0;
    int          n_gap_eq = 0;
    int          nop_run  = 0;
    logic [1:0]  prev_op  = 2'h0;

    // Port model: register space answers in the next cycle, memory space raises pending for one cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_rdata      <= 64'h0;
            bus.mem_op_pending <= 1'b0;
        end else begin
            if (bus.mem_op == MEM_OP_WRITE) begin
                mem_arr[bus.mem_addr[6:3]] <= bus.mem_data;
            end
            if (bus.mem_op == MEM_OP_READ) begin
                if (bus.mem_addr[63]) begin
                    bus.mem_op_pending <= 1'b0;
                    if (bus.mem_addr == MEM_ADDR_HALTED) begin
                        halted_reads  <= halted_reads + 1;
                        bus.mem_rdata <= (halted_reads < halted_zero_until) ? 64'h0 : 64'h1;
                    end else begin
                        bus.mem_rdata <= 64'h0;
                    end
                end else begin
                    bus.mem_op_pending <= 1'b1;
                    bus.mem_rdata      <= mem_arr[bus.mem_addr[6:3]];
                end
            end else begin
                bus.mem_op_pending <= pend_stuck;
            end
        end
    end

    // Port op monitor sampled mid-cycle: op counts, multi-cycle ops, illegal op 3, poll spacing.
    always @(negedge clk) begin
        prev_op <= bus.mem_op;
        if (bus.mem_op == MEM_OP_READ)  n_read  <= n_read + 1;
        if (bus.mem_op == MEM_OP_WRITE) n_write <= n_write + 1;
        if (bus.mem_op == 2'h3)         n_bad   <= n_bad + 1;
        if ((bus.mem_op != MEM_OP_NOP) && (prev_op != MEM_OP_NOP)) n_long <= n_long + 1;
        // between poll reads: one WAIT cycle plus POLL_GAP GAP cycles of NOP
        if ((bus.mem_op == MEM_OP_READ) && (nop_run == POLL_GAP + 1)) n_gap_eq <= n_gap_eq + 1;
        nop_run <= (bus.mem_op == MEM_OP_NOP) ? nop_run + 1 : 0;
    end

    // Drive one request (starting just after a rising edge) and queue its expected response.
    task automatic send_req(input logic [1:0] op, input logic [63:0] addr, input logic [63:0] data,
                            input logic [63:0] e_data, input logic e_to);
        int t;
        t = 0;
        while ((bus.req_ready !== 1'b1) && (t < 100)) begin
            @(posedge clk); #1; t++;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_data  = data;
        exp_q.push_back('{data: e_data, timeout: e_to});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op    = MEM_OP_NOP;
    endtask

    // Wait (bounded) for o_rsp_valid and pop the matching scoreboard entry.
    task automatic get_rsp(output bit got, output int lat, output logic [63:0] d, output logic to,
                           output logic [63:0] ed, output logic et);
        exp_t e;
        lat = 1;
        while ((bus.rsp_valid !== 1'b1) && (lat < 200)) begin
            @(posedge clk); #1; lat++;
        end
        got = (bus.rsp_valid === 1'b1);
        d   = bus.rsp_data;
        to  = bus.rsp_timeout;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ed = e.data;
            et = e.timeout;
        end else begin
            ed = 64'hx;
            et = 1'bx;
        end
    endtask

    task automatic accept_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_timeout, bus.mem_op} !== 5'b1_0_0_00) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/vld/to/op=%b want 10000",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_timeout, bus.mem_op});
        end
        checks++;
        if ({bus.rsp_data, bus.mem_addr, bus.mem_data} !== 192'h0) begin
            errors++;
            $display("FAIL reset_data: got rsp_data=%h mem_addr=%h mem_data=%h want all 0",
                     bus.rsp_data, bus.mem_addr, bus.mem_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        bit got; int lat; logic [63:0] d, ed; logic to, et; int w0, l0;
        w0 = n_write; l0 = n_long;
        send_req(MEM_OP_WRITE, 64'h10, 64'hDEAD_BEEF, 64'h0, 1'b0);
        get_rsp(got, lat, d, to, ed, et);
        checks++;
        if (!got || ({d, to} !== {ed, et})) begin
            errors++;
            $display("FAIL write_rsp: got valid=%0b data=%h to=%b want data=%h to=%b", got, d, to, ed, et);
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL write_latency: got %0d want 3", lat); end
        accept_rsp();
        checks++;
        if ((n_write - w0 != 1) || (n_long != l0)) begin
            errors++;
            $display("FAIL write_op_pulse: got writes=%0d long=%0d want 1 and 0", n_write - w0, n_long - l0);
        end
        checks++;
        if (mem_arr[2] !== 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_port_data: got %h want deadbeef", mem_arr[2]);
        end
    endtask

    task automatic test_read();
        bit got; int lat; logic [63:0] d, ed; logic to, et; int r0, l0;
        r0 = n_read; l0 = n_long;
        send_req(MEM_OP_READ, 64'h10, 64'h0, 64'hDEAD_BEEF, 1'b0);
        get_rsp(got, lat, d, to, ed, et);
        checks++;
        if (!got || ({d, to} !== {ed, et})) begin
            errors++;
            $display("FAIL read_rsp: got valid=%0b data=%h to=%b want data=%h to=%b", got, d, to, ed, et);
        end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL read_latency: got %0d want 4", lat); end
        accept_rsp();
        checks++;
        if ((n_read - r0 != 1) || (n_long != l0)) begin
            errors++;
            $display("FAIL read_op_pulse: got reads=%0d long=%0d want 1 and 0", n_read - r0, n_long - l0);
        end
    endtask

    task automatic test_reg_read();
        bit got; int lat; logic [63:0] d, ed; logic to, et;
        send_req(MEM_OP_READ, 64'h8000_0000_0000_0010, 64'h0, 64'h0, 1'b0);
        get_rsp(got, lat, d, to, ed, et);
        checks++;
        if (!got || ({d, to} !== {ed, et}) || (lat != 3)) begin
            errors++;
            $display("FAIL reg_read: got valid=%0b data=%h to=%b lat=%0d want data=%h to=%b lat=3",
                     got, d, to, lat, ed, et);
        end
        accept_rsp();
    endtask

    task automatic test_nop();
        bit got; int lat; logic [63:0] d, ed; logic to, et; int r0, w0;
        r0 = n_read; w0 = n_write;
        send_req(MEM_OP_NOP, 64'h10, 64'h55, 64'h0, 1'b0);
        get_rsp(got, lat, d, to, ed, et);
        checks++;
        if (!got || ({d, to} !== {ed, et}) || (lat != 1)) begin
            errors++;
            $display("FAIL nop_rsp: got valid=%0b data=%h to=%b lat=%0d want data=%h to=%b lat=1",
                     got, d, to, lat, ed, et);
        end
        accept_rsp();
        checks++;
        if ((n_read != r0) || (n_write != w0)) begin
            errors++;
            $display("FAIL nop_port_idle: got reads=%0d writes=%0d want 0 and 0", n_read - r0, n_write - w0);
        end
    endtask

    task automatic test_poll();
        bit got; int lat; logic [63:0] d, ed; logic to, et; int r0, g0, l0;
        repeat (20) @(posedge clk);
        #1;
        halted_zero_until = halted_reads + 3;
        r0 = n_read; g0 = n_gap_eq; l0 = n_long;
        send_req(REQ_OP_POLL, MEM_ADDR_HALTED, 64'h0, 64'h1, 1'b0);
        get_rsp(got, lat, d, to, ed, et);
        checks++;
        if (!got || ({d, to} !== {ed, et})) begin
            errors++;
            $display("FAIL poll_rsp: got valid=%0b data=%h to=%b want data=%h to=%b", got, d, to, ed, et);
        end
        // 3 failed attempts of ISSUE+WAIT+GAP, then ISSUE+WAIT
        checks++;
        if (lat != 3 + 3 * (2 + POLL_GAP)) begin
            errors++;
            $display("FAIL poll_latency: got %0d want %0d", lat, 3 + 3 * (2 + POLL_GAP));
        end
        accept_rsp();
        checks++;
        if ((n_read - r0 != 4) || (n_gap_eq - g0 != 3) || (n_long != l0) || (n_bad != 0)) begin
            errors++;
            $display("FAIL poll_ops: got reads=%0d gaps=%0d long=%0d bad=%0d want 4 3 0 0",
                     n_read - r0, n_gap_eq - g0, n_long - l0, n_bad);
        end
    endtask

    task automatic test_poll_timeout();
        bit got; int lat; logic [63:0] d, ed; logic to, et; int r0, g0;
        repeat (20) @(posedge clk);
        #1;
        halted_zero_until = halted_reads + 1000;
        r0 = n_read; g0 = n_gap_eq;
        send_req(REQ_OP_POLL, MEM_ADDR_HALTED, 64'h0, 64'h0, 1'b1);
        get_rsp(got, lat, d, to, ed, et);
        checks++;
        if (!got || ({d, to} !== {ed, et})) begin
            errors++;
            $display("FAIL poll_timeout_rsp: got valid=%0b data=%h to=%b want data=%h to=%b", got, d, to, ed, et);
        end
        checks++;
        if (lat != 3 + (POLL_LIMIT - 1) * (2 + POLL_GAP)) begin
            errors++;
            $display("FAIL poll_timeout_latency: got %0d want %0d", lat, 3 + (POLL_LIMIT - 1) * (2 + POLL_GAP));
        end
        accept_rsp();
        checks++;
        if ((n_read - r0 != POLL_LIMIT) || (n_gap_eq - g0 != POLL_LIMIT - 1)) begin
            errors++;
            $display("FAIL poll_timeout_reads: got reads=%0d gaps=%0d want %0d %0d",
                     n_read - r0, n_gap_eq - g0, POLL_LIMIT, POLL_LIMIT - 1);
        end
    endtask

    task automatic test_pend_timeout();
        bit got; int lat; logic [63:0] d, ed; logic to, et; int r0, l0;
        r0 = n_read; l0 = n_long;
        pend_stuck = 1'b1;
        send_req(MEM_OP_READ, 64'h10, 64'h0, 64'h0, 1'b1);
        get_rsp(got, lat, d, to, ed, et);
        checks++;
        if (!got || ({d, to} !== {ed, et})) begin
            errors++;
            $display("FAIL pend_timeout_rsp: got valid=%0b data=%h to=%b want data=%h to=%b", got, d, to, ed, et);
        end
        checks++;
        if (lat != 2 + PEND_LIMIT) begin
            errors++;
            $display("FAIL pend_timeout_latency: got %0d want %0d", lat, 2 + PEND_LIMIT);
        end
        pend_stuck = 1'b0;
        accept_rsp();
        checks++;
        if ((n_read - r0 != 1) || (n_long != l0)) begin
            errors++;
            $display("FAIL pend_timeout_ops: got reads=%0d long=%0d want 1 and 0", n_read - r0, n_long - l0);
        end
    endtask

    task automatic test_reset_mid();
        bit got; int lat; logic [63:0] d, ed; logic to, et;
        // reset while the op is on the port
        pend_stuck = 1'b1;
        send_req(MEM_OP_READ, 64'h10, 64'h0, 64'hDEAD_BEEF, 1'b0);
        checks++;
        if (bus.mem_op !== MEM_OP_READ) begin
            errors++;
            $display("FAIL rst_issue_pre: got mem_op=%0d want 1", bus.mem_op);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.mem_op, bus.req_ready, bus.mem_addr} !== {MEM_OP_NOP, 1'b1, 64'h0}) begin
            errors++;
            $display("FAIL rst_issue: got mem_op=%0d rdy=%b addr=%h want 0 1 0", bus.mem_op, bus.req_ready, bus.mem_addr);
        end
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        // reset while waiting on pending
        send_req(MEM_OP_READ, 64'h10, 64'h0, 64'hDEAD_BEEF, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_wait_pre: got rdy/vld=%b want 00", {bus.req_ready, bus.rsp_valid});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_timeout, bus.mem_op} !== 5'b1_0_0_00 ||
            {bus.rsp_data, bus.mem_addr, bus.mem_data} !== 192'h0) begin
            errors++;
            $display("FAIL rst_wait: got rdy/vld/to/op=%b rsp_data=%h addr=%h want 10000 and zeros",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_timeout, bus.mem_op}, bus.rsp_data, bus.mem_addr);
        end
        pend_stuck = 1'b0;
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        // next request completes normally
        send_req(MEM_OP_READ, 64'h10, 64'h0, 64'hDEAD_BEEF, 1'b0);
        get_rsp(got, lat, d, to, ed, et);
        checks++;
        if (!got || ({d, to} !== {ed, et}) || (lat != 4)) begin
            errors++;
            $display("FAIL rst_recover: got valid=%0b data=%h to=%b lat=%0d want data=%h to=%b lat=4",
                     got, d, to, lat, ed, et);
        end
        accept_rsp();
    endtask

    task automatic test_back_to_back();
        bit got; int lat; logic [63:0] d, ed; logic to, et;
        logic [63:0] wval;
        logic [1:0]  ops  [2];
        wval   = 64'h1234_5678_9ABC_DEF0;
        ops[0] = MEM_OP_WRITE;
        ops[1] = MEM_OP_READ;
        for (int k = 0; k < 2; k++) begin
            bus.rsp_ready = 1'b0;
            send_req(ops[k], 64'h18, wval, (k == 0) ? 64'h0 : wval, 1'b0);
            get_rsp(got, lat, d, to, ed, et);
            checks++;
            if (!got || ({d, to} !== {ed, et}) || (lat != 3 + k)) begin
                errors++;
                $display("FAIL b2b_rsp%0d: got valid=%0b data=%h to=%b lat=%0d want data=%h to=%b lat=%0d",
                         k, got, d, to, lat, ed, et, 3 + k);
            end
            for (int s = 0; s < 4; s++) begin
                @(posedge clk); #1;
                checks++;
                if ({bus.rsp_valid, bus.req_ready, bus.rsp_timeout} !== 3'b100 || bus.rsp_data !== ed) begin
                    errors++;
                    $display("FAIL b2b_stall%0d: got vld/rdy/to=%b data=%h want 100 data=%h",
                             k, {bus.rsp_valid, bus.req_ready, bus.rsp_timeout}, bus.rsp_data, ed);
                end
            end
            accept_rsp();
            checks++;
            if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
                errors++;
                $display("FAIL b2b_accept%0d: got vld/rdy=%b want 01", k, {bus.rsp_valid, bus.req_ready});
            end
        end
        bus.rsp_ready = 1'b1;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = MEM_OP_NOP;
        bus.req_addr  = 64'h0;
        bus.req_data  = 64'h0;
        bus.rsp_ready = 1'b1;
        pend_stuck    = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_reg_read();
        test_nop();
        test_poll();
        test_poll_timeout();
        test_pend_timeout();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a scenario never returns.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
